// File: rtl/alu_cmd_issuer_if.sv
// Command, ALU-drive and result streams of the ALU command issuer, bundled with issuer/environment modports.
interface alu_cmd_issuer_if #(
  parameter int N  = 32,
  parameter int TW = 4,
  parameter int CW = 16
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_opc;
  logic [N-1:0]  cmd_a;
  logic [N-1:0]  cmd_b;
  logic [TW-1:0] cmd_tag;

  logic [2:0]    alu_opc;
  logic [N-1:0]  alu_a;
  logic [N-1:0]  alu_b;
  logic [N-1:0]  alu_out;
  logic          alu_zero;

  logic          res_valid;
  logic          res_ready;
  logic [N-1:0]  res_data;
  logic          res_zero;
  logic          res_err;
  logic [TW-1:0] res_tag;
  logic [CW-1:0] ops_done;

  modport master (
    input  cmd_valid, cmd_opc, cmd_a, cmd_b, cmd_tag,
    output cmd_ready,
    output alu_opc, alu_a, alu_b,
    input  alu_out, alu_zero,
    output res_valid, res_data, res_zero, res_err, res_tag, ops_done,
    input  res_ready
  );

  modport slave (
    output cmd_valid, cmd_opc, cmd_a, cmd_b, cmd_tag,
    input  cmd_ready,
    input  alu_opc, alu_a, alu_b,
    output alu_out, alu_zero,
    input  res_valid, res_data, res_zero, res_err, res_tag, ops_done,
    output res_ready
  );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Generic pointer-based FIFO plus the ALU command issuer that drains it into a registered result stage.

// Purpose: DEPTH-entry FIFO with (log2(DEPTH)+1)-bit pointers; full/empty from MSB compare.
// Latency: write visible at the head one edge after push into an empty FIFO.
// Backpressure: push ignored when full, pop ignored when empty; no same-cycle bypass.
module alu_cmd_issuer_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wr_dat,
  input  logic         pop,
  output logic [W-1:0] rd_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_dat = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_dat;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end
endmodule

// Purpose: queue ALU commands, drive the head onto an external combinational ALU, register tagged results.
// Latency: command pushed at edge k into an idle issuer -> res_valid after edge k+1; 1 result/cycle sustained.
// Backpressure: cmd_ready = !full (no bypass); result held stable while res_valid && !res_ready.
module alu_cmd_issuer #(
  parameter int N     = 32,
  parameter int DEPTH = 4,
  parameter int TW    = 4,
  parameter int CW    = 16
) (
  input  logic           clk,
  input  logic           rst,
  alu_cmd_issuer_if.master bus
);
  typedef struct packed {
    logic [2:0]    opc;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic [TW-1:0] tag;
  } cmd_t;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  localparam logic [CW-1:0] CNT_ONE = 1;

  cmd_t          wr_cmd;
  cmd_t          head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          capture;
  logic          illegal;
  logic          res_fire;

  state_t        state_q,    state_d;
  logic [N-1:0]  res_data_q, res_data_d;
  logic          res_zero_q, res_zero_d;
  logic          res_err_q,  res_err_d;
  logic [TW-1:0] res_tag_q,  res_tag_d;
  logic [CW-1:0] ops_done_q, ops_done_d;

  always_comb begin
    wr_cmd.opc = bus.cmd_opc;
    wr_cmd.a   = bus.cmd_a;
    wr_cmd.b   = bus.cmd_b;
    wr_cmd.tag = bus.cmd_tag;
  end

  alu_cmd_issuer_fifo #(
    .W     ($bits(cmd_t)),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .wr_dat (wr_cmd),
    .pop    (capture),
    .rd_dat (head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign push          = bus.cmd_valid && !fifo_full;
  assign bus.cmd_ready = !fifo_full;

  // The ALU sees quiet zeros whenever there is nothing to issue.
  assign bus.alu_opc = fifo_empty ? 3'b000 : head.opc;
  assign bus.alu_a   = fifo_empty ? '0     : head.a;
  assign bus.alu_b   = fifo_empty ? '0     : head.b;

  assign illegal  = (head.opc[2:1] == 2'b11);
  assign res_fire = (state_q == S_FULL) && bus.res_ready;
  assign capture  = !fifo_empty && ((state_q == S_EMPTY) || bus.res_ready);

  always_comb begin
    state_d    = state_q;
    res_data_d = res_data_q;
    res_zero_d = res_zero_q;
    res_err_d  = res_err_q;
    res_tag_d  = res_tag_q;
    ops_done_d = ops_done_q;

    case (state_q)
      S_EMPTY: if (capture) state_d = S_FULL;
      S_FULL:  if (bus.res_ready && !capture) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase

    if (capture) begin
      res_data_d = illegal ? '0   : bus.alu_out;
      res_zero_d = illegal ? 1'b0 : bus.alu_zero;
      res_err_d  = illegal;
      res_tag_d  = head.tag;
    end

    if (res_fire) ops_done_d = ops_done_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_EMPTY;
      res_data_q <= '0;
      res_zero_q <= 1'b0;
      res_err_q  <= 1'b0;
      res_tag_q  <= '0;
      ops_done_q <= '0;
    end else begin
      state_q    <= state_d;
      res_data_q <= res_data_d;
      res_zero_q <= res_zero_d;
      res_err_q  <= res_err_d;
      res_tag_q  <= res_tag_d;
      ops_done_q <= ops_done_d;
    end
  end

  assign bus.res_valid = (state_q == S_FULL);
  assign bus.res_data  = res_data_q;
  assign bus.res_zero  = res_zero_q;
  assign bus.res_err   = res_err_q;
  assign bus.res_tag   = res_tag_q;
  assign bus.ops_done  = ops_done_q;
endmodule
